// File: rtl/goe.sv
`default_nettype none
// ============================================================================
// Module   : goe
// Brief    : Packet egress stage. Buffers packet words, keep/drop verdicts and
//            PHVs; forwards kept packets with the head payload replaced by
//            phv[1023:896], discards dropped ones; registered config slice.
//            Optional macro GOE_META_STRIP_EN strips the metadata head word.
// Revision : 1.0
// ============================================================================
module goe #(
   parameter             PLATFORM   = "Xilinx",
   parameter logic [7:0] LMID       = 8'd5,
   parameter int         DFIFO_AW   = 8,
   parameter int         PFIFO_AW   = 4,
   parameter int         ALF_MARGIN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_goe_data_wr,
   input  logic [133:0]  in_goe_data,
   input  logic          in_goe_valid_wr,
   input  logic          in_goe_valid,
   output logic          out_goe_alf,
   input  logic [1023:0] in_goe_phv,
   input  logic          in_goe_phv_wr,
   output logic          out_goe_phv_alf,
   output logic [133:0]  out_goe_data,
   output logic          out_goe_data_wr,
   output logic          out_goe_valid_wr,
   output logic          out_goe_valid,
   input  logic          in_goe_alf,
   input  logic [133:0]  cin_goe_data,
   input  logic          cin_goe_data_wr,
   output logic          cout_goe_ready,
   output logic [133:0]  cout_goe_data,
   output logic          cout_goe_data_wr,
   input  logic          cin_goe_ready,
   output logic [31:0]   goe_pkt_tx_cnt,
   output logic [31:0]   goe_pkt_drop_cnt,
   output logic          goe_ovf_err
);

   localparam int                c_DWORDS  = 1 << DFIFO_AW;
   localparam int                c_PWORDS  = 1 << PFIFO_AW;
   localparam logic [DFIFO_AW:0] c_DDEPTH  = (DFIFO_AW+1)'(c_DWORDS);
   localparam logic [DFIFO_AW:0] c_DMARGIN = (DFIFO_AW+1)'(ALF_MARGIN);
   localparam logic [PFIFO_AW:0] c_PDEPTH  = (PFIFO_AW+1)'(c_PWORDS);
   localparam logic [PFIFO_AW:0] c_VMARGIN = (PFIFO_AW+1)'(2);
   localparam logic [PFIFO_AW:0] c_PMARGIN = (PFIFO_AW+1)'(4);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   // ---------------- data FIFO (show-ahead) ----------------
   logic [133:0]      r_dmem [c_DWORDS];
   logic [DFIFO_AW:0] r_dwp, r_drp;
   logic [DFIFO_AW:0] w_dcnt, w_dfree;
   logic              w_dempty, w_dfull, w_dpush, w_dpop;
   logic [133:0]      w_dout;

   assign w_dcnt   = r_dwp - r_drp;
   assign w_dfree  = c_DDEPTH - w_dcnt;
   assign w_dempty = (w_dcnt == '0);
   assign w_dfull  = (w_dcnt == c_DDEPTH);
   assign w_dpush  = in_goe_data_wr & ~w_dfull;
   assign w_dout   = r_dmem[r_drp[DFIFO_AW-1:0]];

   // ---------------- verdict FIFO (show-ahead) ----------------
   logic [c_PWORDS-1:0] r_vmem;
   logic [PFIFO_AW:0]   r_vwp, r_vrp;
   logic [PFIFO_AW:0]   w_vcnt, w_vfree;
   logic                w_vempty, w_vfull, w_vpush, w_vout;

   assign w_vcnt   = r_vwp - r_vrp;
   assign w_vfree  = c_PDEPTH - w_vcnt;
   assign w_vempty = (w_vcnt == '0);
   assign w_vfull  = (w_vcnt == c_PDEPTH);
   assign w_vpush  = in_goe_valid_wr & ~w_vfull;
   assign w_vout   = r_vmem[r_vrp[PFIFO_AW-1:0]];

   // ---------------- PHV FIFO (show-ahead) ----------------
   logic [1023:0]     r_pmem [c_PWORDS];
   logic [PFIFO_AW:0] r_pwp, r_prp;
   logic [PFIFO_AW:0] w_pcnt, w_pfree;
   logic              w_pempty, w_pfull, w_ppush;
   logic [1023:0]     w_pout;

   assign w_pcnt   = r_pwp - r_prp;
   assign w_pfree  = c_PDEPTH - w_pcnt;
   assign w_pempty = (w_pcnt == '0);
   assign w_pfull  = (w_pcnt == c_PDEPTH);
   assign w_ppush  = in_goe_phv_wr & ~w_pfull;
   assign w_pout   = r_pmem[r_prp[PFIFO_AW-1:0]];

   // ---------------- control decode ----------------
   state_t r_state;
   logic   r_first;
   logic   w_meta_rdy, w_go_send, w_go_disc, w_meta_pop, w_is_tail;

   assign w_meta_rdy = ~w_vempty & ~w_pempty & ~w_dempty;
   assign w_go_send  = (r_state == IDLE) & w_meta_rdy & w_vout & ~in_goe_alf;
   assign w_go_disc  = (r_state == IDLE) & w_meta_rdy & ~w_vout;
   assign w_meta_pop = w_go_send | w_go_disc;
   assign w_dpop     = ((r_state == SEND) | (r_state == DISCARD)) & ~w_dempty;
   assign w_is_tail  = (w_dout[133:132] == 2'b10);

   // Storage arrays carry no reset; only pointers define FIFO contents.
   always_ff @(posedge clk) begin
      if (w_dpush) r_dmem[r_dwp[DFIFO_AW-1:0]] <= in_goe_data;
      if (w_vpush) r_vmem[r_vwp[PFIFO_AW-1:0]] <= in_goe_valid;
      if (w_ppush) r_pmem[r_pwp[PFIFO_AW-1:0]] <= in_goe_phv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwp           <= '0;
         r_drp           <= '0;
         r_vwp           <= '0;
         r_vrp           <= '0;
         r_pwp           <= '0;
         r_prp           <= '0;
         goe_ovf_err     <= 1'b0;
         out_goe_alf     <= 1'b0;
         out_goe_phv_alf <= 1'b0;
      end else begin
         if (w_dpush)    r_dwp <= r_dwp + 1'b1;
         if (w_dpop)     r_drp <= r_drp + 1'b1;
         if (w_vpush)    r_vwp <= r_vwp + 1'b1;
         if (w_meta_pop) r_vrp <= r_vrp + 1'b1;
         if (w_ppush)    r_pwp <= r_pwp + 1'b1;
         if (w_meta_pop) r_prp <= r_prp + 1'b1;
         if ((in_goe_data_wr & w_dfull) | (in_goe_valid_wr & w_vfull) |
             (in_goe_phv_wr & w_pfull))
            goe_ovf_err <= 1'b1;
         out_goe_alf     <= (w_dfree < c_DMARGIN) | (w_vfree < c_VMARGIN);
         out_goe_phv_alf <= (w_pfree < c_PMARGIN);
      end
   end

   // ---------------- egress FSM ----------------
`ifdef GOE_META_STRIP_EN
   logic r_second;
`else
   logic [127:0] r_meta;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_first          <= 1'b0;
`ifdef GOE_META_STRIP_EN
         r_second         <= 1'b0;
`else
         r_meta           <= '0;
`endif
         out_goe_data     <= '0;
         out_goe_data_wr  <= 1'b0;
         out_goe_valid_wr <= 1'b0;
         out_goe_valid    <= 1'b0;
         goe_pkt_tx_cnt   <= '0;
         goe_pkt_drop_cnt <= '0;
      end else begin
         out_goe_data_wr  <= 1'b0;
         out_goe_valid_wr <= 1'b0;
         out_goe_valid    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_go_send) begin
                  r_state <= SEND;
                  r_first <= 1'b1;
`ifndef GOE_META_STRIP_EN
                  r_meta  <= w_pout[1023:896];
`endif
               end else if (w_go_disc) begin
                  r_state <= DISCARD;
               end
            end
            SEND: begin
               if (w_dpop) begin
                  r_first <= 1'b0;
`ifdef GOE_META_STRIP_EN
                  r_second <= r_first;
                  if (r_first) begin
                     // A packet consisting only of metadata has nothing to send.
                     if (w_is_tail) begin
                        goe_pkt_drop_cnt <= goe_pkt_drop_cnt + 32'd1;
                        r_state          <= IDLE;
                     end
                  end else begin
                     out_goe_data_wr <= 1'b1;
                     out_goe_data    <= r_second ? {2'b01, w_dout[131:0]} : w_dout;
                     if (w_is_tail) begin
                        out_goe_valid_wr <= 1'b1;
                        out_goe_valid    <= 1'b1;
                        goe_pkt_tx_cnt   <= goe_pkt_tx_cnt + 32'd1;
                        r_state          <= IDLE;
                     end
                  end
`else
                  out_goe_data_wr <= 1'b1;
                  out_goe_data    <= r_first ? {w_dout[133:128], r_meta} : w_dout;
                  if (w_is_tail) begin
                     out_goe_valid_wr <= 1'b1;
                     out_goe_valid    <= 1'b1;
                     goe_pkt_tx_cnt   <= goe_pkt_tx_cnt + 32'd1;
                     r_state          <= IDLE;
                  end
`endif
               end
            end
            DISCARD: begin
               if (w_dpop & w_is_tail) begin
                  goe_pkt_drop_cnt <= goe_pkt_drop_cnt + 32'd1;
                  r_state          <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ---------------- config slice with 2-entry skid ----------------
   // Ready is registered, so one word may arrive after downstream stalls;
   // two entries absorb the in-flight word plus the one awaiting output.
   logic [133:0] r_cq [2];
   logic [1:0]   r_cwp, r_crp, w_ccnt;
   logic         w_cpush, w_cpop;

   assign w_ccnt  = r_cwp - r_crp;
   assign w_cpush = cin_goe_data_wr & cout_goe_ready & (w_ccnt != 2'd2);
   assign w_cpop  = (w_ccnt != 2'd0) & cin_goe_ready;

   always_ff @(posedge clk) begin
      if (w_cpush) r_cq[r_cwp[0]] <= cin_goe_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cwp            <= '0;
         r_crp            <= '0;
         cout_goe_ready   <= 1'b1;
         cout_goe_data    <= '0;
         cout_goe_data_wr <= 1'b0;
      end else begin
         cout_goe_ready   <= cin_goe_ready;
         cout_goe_data_wr <= w_cpop;
         if (w_cpush) r_cwp <= r_cwp + 1'b1;
         if (w_cpop) begin
            r_crp         <= r_crp + 1'b1;
            cout_goe_data <= r_cq[r_crp[0]];
         end
      end
   end

   // Module ID and vendor selection are carried for integration only.
   logic w_unused;
   assign w_unused = ^{LMID, (PLATFORM == "Xilinx"), w_pout};

endmodule
`default_nettype wire
